prism_sp_puzzle_axi_rd_arbiter: RTL and testbench

- Shares one AXI read master (AR + R) between N_REQ puzzle stages on the TX path, e.g. descriptor fetch in ring acquire and payload fetch in the DMA read stage.
- Round-robin arbiter on AR; an in-order routing FIFO steers each R burst back to the requester that issued it.
- Single AXI ID; relies on AXI in-order return for the same ID. Sits between the stage modules and axi_ma_ar/axi_ma_r.

---
 rtl/prism_sp_config_pkg.sv | 22 ++
 rtl/prism_sp_rd_route_fifo.sv | 63 ++++++
 rtl/prism_sp_puzzle_axi_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_prism_sp_puzzle_axi_rd_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prism_sp_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prism_sp_config (package)
// Description : Shared constants and types for the TX-path AXI read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package prism_sp_config;

    localparam int SYSTEM_ADDR_WIDTH         = 64;
    localparam int DEFAULT_MAX_OUTSTANDING   = 4;
    localparam int MAX_N_REQ                 = 4;

    // Sized for the largest supported requester count so every build shares one type
    typedef logic [$clog2(MAX_N_REQ)-1:0] rd_req_idx_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } ar_state_t;

endpackage
`default_nettype wire

// File: rtl/prism_sp_rd_route_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prism_sp_rd_route_fifo
// Description : In-order FIFO of requester indices steering R bursts back.
// Revision    : 1.0 - initial release
// ============================================================================
module prism_sp_rd_route_fifo
    import prism_sp_config::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  rd_req_idx_t                i_push_idx,
    input  logic                       i_pop,
    output rd_req_idx_t                o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    rd_req_idx_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == (c_ptr_w+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_idx;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/prism_sp_puzzle_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prism_sp_puzzle_axi_rd_arbiter
// Description : Round-robin AR arbiter with in-order R routing for one AXI ID.
// Revision    : 1.0 - initial release
// ============================================================================
module prism_sp_puzzle_axi_rd_arbiter
    import prism_sp_config::*;
#(
    parameter int N_REQ           = 2,
    parameter int ADDR_WIDTH      = SYSTEM_ADDR_WIDTH,
    parameter int DATA_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [N_REQ-1:0]                s_arvalid,
    output logic [N_REQ-1:0]                s_arready,
    input  logic [N_REQ*ADDR_WIDTH-1:0]     s_araddr,
    input  logic [N_REQ*8-1:0]              s_arlen,
    output logic [N_REQ-1:0]                s_rvalid,
    input  logic [N_REQ-1:0]                s_rready,
    output logic [DATA_WIDTH-1:0]           s_rdata,
    output logic                            s_rlast,
    output logic [1:0]                      s_rresp,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ADDR_WIDTH-1:0]           m_araddr,
    output logic [7:0]                      m_arlen,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic                            m_rlast,
    input  logic [1:0]                      m_rresp,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                            err_orphan_r
);

    ar_state_t             r_state, w_state_nxt;
    rd_req_idx_t           r_idx, r_rr_ptr, w_pick, w_head;
    logic [ADDR_WIDTH-1:0] r_addr, w_sel_addr;
    logic [7:0]            r_len, w_sel_len;
    logic                  r_err_orphan;
    logic                  w_load, w_ar_hs, w_pop, w_sel_valid, w_head_ready;
    logic                  w_fifo_full, w_fifo_empty;

    // First requester at or after ptr, wrapping; smallest offset wins
    function automatic rd_req_idx_t rr_pick(input logic [N_REQ-1:0] req, input rd_req_idx_t ptr);
        rd_req_idx_t pick;
        pick = ptr;
        for (int k = N_REQ-1; k >= 0; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && (i == (int'(ptr) + k) % N_REQ)) pick = rd_req_idx_t'(i);
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_pick      = rr_pick(s_arvalid, r_rr_ptr);
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rd_req_idx_t'(i) == w_pick) begin
                w_sel_addr = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = s_arlen[i*8 +: 8];
            end
            if (rd_req_idx_t'(i) == r_idx) w_sel_valid = s_arvalid[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_full && (|s_arvalid)) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (m_arready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign m_arvalid = (r_state == S_GRANT);
    assign m_araddr  = r_addr;
    assign m_arlen   = r_len;
    assign w_ar_hs   = m_arvalid && m_arready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_rr_ptr     <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_idx  <= w_pick;
                r_addr <= w_sel_addr;
                r_len  <= w_sel_len;
            end
            if (w_ar_hs) begin
                r_rr_ptr <= (r_idx == rd_req_idx_t'(N_REQ-1)) ? '0 : rd_req_idx_t'(r_idx + 1'b1);
            end
            if (m_rvalid && w_fifo_empty) r_err_orphan <= 1'b1;
        end
    end

    always_comb begin
        s_arready    = '0;
        s_rvalid     = '0;
        w_head_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rd_req_idx_t'(i) == r_idx)  s_arready[i] = w_ar_hs;
            if (rd_req_idx_t'(i) == w_head) begin
                s_rvalid[i]  = m_rvalid && !w_fifo_empty;
                w_head_ready = s_rready[i];
            end
        end
    end

    assign m_rready     = w_head_ready && !w_fifo_empty;
    assign w_pop        = m_rvalid && m_rready && m_rlast;
    assign s_rdata      = m_rdata;
    assign s_rlast      = m_rlast;
    assign s_rresp      = m_rresp;
    assign err_orphan_r = r_err_orphan;

    prism_sp_rd_route_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk        (clock),
        .rst_n      (resetn),
        .i_push     (w_ar_hs),
        .i_push_idx (r_idx),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (outstanding),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

`ifndef SYNTHESIS
    a_grant_req_held: assert property (@(posedge clock) disable iff (!resetn)
        (r_state == S_GRANT) |-> w_sel_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_prism_sp_puzzle_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prism_sp_puzzle_axi_rd_arbiter
// Description : Directed scoreboard bench for the AXI read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prism_sp_puzzle_axi_rd_arbiter;

    localparam int c_aw = 32;
    localparam int c_dw = 128;

    typedef struct { logic [1:0] onehot; logic [c_aw-1:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { int idx; int len; } route_t;
    typedef struct { logic [1:0] req; logic [c_dw-1:0] data; logic last; } r_exp_t;

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic [1:0]         s_arvalid = '0, s_arready, s_rvalid, s_rready = '0;
    logic [2*c_aw-1:0]  s_araddr = '0;
    logic [15:0]        s_arlen = '0;
    logic [c_dw-1:0]    s_rdata, m_rdata = '0;
    logic               s_rlast, m_rlast = 1'b0, m_arvalid, m_arready = 1'b0;
    logic [1:0]         s_rresp, m_rresp = '0;
    logic [c_aw-1:0]    m_araddr;
    logic [7:0]         m_arlen;
    logic               m_rvalid = 1'b0, m_rready;
    logic [2:0]         outstanding;
    logic               err_orphan_r;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int ar_seen = 0, gcnt0 = 0, gcnt1 = 0, burst_id = 0, mdl_ptr = 0;
    ar_exp_t exp_ar[$];
    route_t  route_q[$];
    r_exp_t  exp_r[$];
    ar_exp_t mon_ar;
    r_exp_t  mon_r;

    prism_sp_puzzle_axi_rd_arbiter #(
        .N_REQ(2), .ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw), .MAX_OUTSTANDING(4)
    ) dut (
        .clock(clock), .resetn(resetn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rresp(m_rresp),
        .outstanding(outstanding), .err_orphan_r(err_orphan_r)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Reference round-robin for two requesters
    task automatic predict_push(input logic [1:0] v);
        int pick;
        ar_exp_t e;
        pick = v[mdl_ptr] ? mdl_ptr : 1 - mdl_ptr;
        mdl_ptr = (pick + 1) % 2;
        e.onehot = 2'b01 << pick;
        e.addr   = s_araddr[pick*c_aw +: c_aw];
        e.len    = s_arlen[pick*8 +: 8];
        exp_ar.push_back(e);
        route_q.push_back('{idx: pick, len: int'(e.len)});
    endtask

    task automatic issue(input int req, input logic [c_aw-1:0] addr, input logic [7:0] len);
        logic [1:0] v;
        bit got;
        s_araddr[req*c_aw +: c_aw] = addr;
        s_arlen[req*8 +: 8] = len;
        v = 2'b01 << req;
        predict_push(v);
        s_arvalid = v;
        got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (s_arready[req]) begin got = 1; break; end
        end
        check("issue_accept", got, 1);
        tick();
        s_arvalid = '0;
    endtask

    task automatic r_burst();
        route_t rt;
        r_exp_t b;
        bit got;
        if (route_q.size() == 0) return;
        rt = route_q.pop_front();
        burst_id++;
        for (int k = 0; k <= rt.len; k++) begin
            b.req  = 2'b01 << rt.idx;
            b.data = 128'({32'(burst_id), 32'(k)});
            b.last = (k == rt.len);
            exp_r.push_back(b);
            m_rvalid = 1'b1; m_rdata = b.data; m_rlast = b.last; m_rresp = 2'b00;
            got = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clock);
                if (k == 0 && c == 0) check("r_head", s_rvalid, b.req);
                if (m_rvalid && m_rready) begin got = 1; break; end
            end
            check("r_beat_accept", got, 1);
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0; s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
        exp_ar.delete(); route_q.delete(); exp_r.delete(); mdl_ptr = 0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (m_arvalid && m_arready) begin
                ar_seen++;
                if (s_arready[0]) gcnt0++;
                if (s_arready[1]) gcnt1++;
                check("ar_expected", exp_ar.size() > 0, 1'b1);
                if (exp_ar.size() > 0) begin
                    mon_ar = exp_ar.pop_front();
                    check("ar_grant", {s_arready, m_araddr, m_arlen}, {mon_ar.onehot, mon_ar.addr, mon_ar.len});
                end
            end
            if (m_rvalid && m_rready) begin
                check("r_expected", exp_r.size() > 0, 1'b1);
                if (exp_r.size() > 0) begin
                    mon_r = exp_r.pop_front();
                    check("r_route", s_rvalid & s_rready, mon_r.req);
                    check("r_data", {s_rdata[126:0], s_rlast}, {mon_r.data[126:0], mon_r.last});
                end
            end
        end
    end

    initial begin
        int base, g0, g1;
        bit found;
        s_rready = 2'b11;
        // Reset state
        repeat (2) @(negedge clock);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_arready", s_arready, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_orphan_r, 0);
        check("rst_araddr", {m_araddr, m_arlen}, 0);
        tick(); resetn = 1'b1; tick();

        // Single requester
        m_arready = 1'b1;
        s_araddr[0 +: c_aw] = 32'h1000; s_arlen[0 +: 8] = 8'd3;
        predict_push(2'b01);
        s_arvalid = 2'b01;
        @(negedge clock);
        check("single_lat0", m_arvalid, 0);
        @(negedge clock);
        check("single_arvalid", m_arvalid, 1);
        check("single_arready", s_arready, 2'b01);
        tick();
        s_arvalid = '0;
        @(negedge clock);
        check("single_out1", outstanding, 1);
        tick();
        r_burst();
        @(negedge clock);
        check("single_out0", outstanding, 0);

        // Contention: both valid, alternating grants from ptr 0
        do_reset();
        m_arready = 1'b1;
        s_araddr = {32'h3000, 32'h2000}; s_arlen = {8'd1, 8'd0};
        for (int g = 0; g < 8; g++) predict_push(2'b11);
        base = ar_seen; g0 = gcnt0; g1 = gcnt1;
        s_arvalid = 2'b11;
        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    tick();
                    if (ar_seen >= base + 8) break;
                end
                s_arvalid = '0;
            end
            begin
                for (int g = 0; g < 8; g++) begin
                    bit ok;
                    ok = 0;
                    for (int c = 0; c < 400; c++) begin
                        if (ar_seen > base + g) begin ok = 1; break; end
                        tick();
                    end
                    check("cont_ar_wait", ok, 1);
                    r_burst();
                end
            end
        join
        check("cont_fair", {32'(gcnt0 - g0), 32'(gcnt1 - g1)}, {32'd4, 32'd4});

        // Backpressure: six requests, no R until FIFO is full
        base = ar_seen;
        for (int g = 0; g < 6; g++) predict_push(2'b11);
        s_arvalid = 2'b11;
        repeat (20) tick();
        @(negedge clock);
        check("bp_outstanding", outstanding, 4);
        check("bp_ar_count", 32'(ar_seen - base), 4);
        check("bp_stalled", m_arvalid, 0);
        tick();
        r_burst();
        found = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (m_arvalid) begin found = 1; break; end
        end
        check("bp_fifth_ar", found, 1);
        tick();
        r_burst();
        found = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (ar_seen >= base + 6) begin found = 1; break; end
        end
        check("bp_sixth_ar", found, 1);
        s_arvalid = '0;
        repeat (4) r_burst();

        // R stall: head is req1 with rready low
        issue(1, 32'h5000, 8'd0);
        issue(0, 32'h6000, 8'd0);
        s_rready = 2'b01;
        begin
            route_t rt;
            r_exp_t b;
            rt = route_q.pop_front();
            burst_id++;
            b.req = 2'b01 << rt.idx; b.data = 128'(32'(burst_id)); b.last = 1'b1;
            exp_r.push_back(b);
            m_rvalid = 1'b1; m_rdata = b.data; m_rlast = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                check("stall_mrready", m_rready, 0);
                check("stall_rvalid", s_rvalid, 2'b10);
            end
            tick();
            s_rready = 2'b11;
            @(negedge clock);
            check("stall_release", m_rready, 1);
            tick();
            m_rvalid = 1'b0; m_rlast = 1'b0;
        end
        r_burst();

        // Simultaneous push and pop at count 2
        issue(0, 32'h8000, 8'd0);
        issue(1, 32'h9000, 8'd0);
        m_arready = 1'b0;
        s_araddr[0 +: c_aw] = 32'hA000; s_arlen[0 +: 8] = 8'd0;
        predict_push(2'b01);
        s_arvalid = 2'b01;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (m_arvalid) begin found = 1; break; end
        end
        check("sim_grant", found, 1);
        tick();
        begin
            route_t rt;
            r_exp_t b;
            rt = route_q.pop_front();
            burst_id++;
            b.req = 2'b01 << rt.idx; b.data = 128'(32'(burst_id)); b.last = 1'b1;
            exp_r.push_back(b);
            m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = b.data; m_rlast = 1'b1;
        end
        @(negedge clock);
        check("sim_both_hs", {s_arready, m_rready, outstanding}, {2'b01, 1'b1, 3'd2});
        tick();
        s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clock);
        check("sim_count", outstanding, 2);
        tick();
        r_burst();
        r_burst();

        // Orphan R beat
        @(negedge clock);
        check("orph_empty", outstanding, 0);
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b1;
        @(negedge clock);
        check("orph_mrready", {m_rready, s_rvalid}, 3'b000);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check("orph_sticky", err_orphan_r, 1);

        // Async reset in the middle of a grant
        m_arready = 1'b0;
        s_arvalid = 2'b01;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (m_arvalid) begin found = 1; break; end
        end
        check("rst_mid_grant", found, 1);
        #2;
        resetn = 1'b0; s_arvalid = '0;
        #1;
        check("rst_async", {m_arvalid, err_orphan_r, outstanding}, 5'b0);
        exp_ar.delete(); route_q.delete(); mdl_ptr = 0;
        tick();
        resetn = 1'b1;
        m_arready = 1'b1;
        tick();
        issue(1, 32'h7000, 8'd2);
        r_burst();
        @(negedge clock);
        check("post_rst_out", outstanding, 0);
        check("end_ar_queue", exp_ar.size(), 0);
        check("end_r_queue", exp_r.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
